// File: rtl/rr_hold_arbiter.sv
// Purpose: registered N-port arbiter, round-robin or fixed priority, with burst hold up to MAX_HOLD cycles.
// Latency: grant appears 1 clk after req_i is sampled; no combinational path from req_i to outputs.
// Backpressure: none inside the arbiter; a requester keeps req_i high until it sees its gnt_o bit.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (deassertion synchronised by the integrator)
//   req_i      request vector, one bit per port
//   gnt_o      registered one-hot grant, all-zero when idle
//   gnt_id_o   binary index of the granted port, 0 when idle
//   gnt_vld_o  high whenever gnt_o is non-zero
module rr_hold_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int RR_MODE   = 1,
    parameter int MAX_HOLD  = 4,
    localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 gnt_vld_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PORTS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NUM_PORTS-1:0]   gnt_q;
    logic [ID_W-1:0]        id_q;
    logic [ID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   owner_req;
    logic                   hold_ok;
    logic                   expired;
    logic [NUM_PORTS-1:0]   cand;
    logic                   found;
    logic [ID_W-1:0]        win_id;
    int                     idx;

    // Arbitration over the current request vector. The result is only used
    // when the owner is not simply extending its hold.
    always_comb begin
        owner_req = (state_q == S_GRANT) && req_i[id_q];
        hold_ok   = owner_req && (cnt_q < CNT_MAX);
        expired   = owner_req && (cnt_q == CNT_MAX);

        cand = req_i;
        // Round-robin hold expiry: give the others a turn. If nobody else is
        // asking, the mask empties the vector and the owner is re-granted.
        if (RR_MODE != 0 && expired) begin
            cand[id_q] = 1'b0;
            if (cand == '0) begin
                cand = req_i;
            end
        end

        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        if (RR_MODE != 0) begin
            // Scan upward from the pointer; explicit wrap keeps non-power-of-2 port counts legal.
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!found && cand[idx]) begin
                    found  = 1'b1;
                    win_id = ID_W'(idx);
                end
            end
        end else begin
            // Downward scan so the lowest set index is the last one written.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found  = 1'b1;
                    win_id = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q <= S_GRANT;
                        gnt_q   <= NUM_PORTS'(1) << win_id;
                        id_q    <= win_id;
                        cnt_q   <= CNT_W'(1);
                        if (RR_MODE != 0) begin
                            ptr_q <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
                        end
                    end
                end
                S_GRANT: begin
                    if (hold_ok) begin
                        // Owner extends its burst; cnt never passes CNT_MAX here.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (found) begin
                        // New ownership, possibly the same port re-granted.
                        gnt_q <= NUM_PORTS'(1) << win_id;
                        id_q  <= win_id;
                        cnt_q <= CNT_W'(1);
                        if (RR_MODE != 0) begin
                            ptr_q <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
                        end
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        id_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    id_q    <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = id_q;
    assign gnt_vld_o = (state_q == S_GRANT);

endmodule
